// File: rtl/axis_stream_tap.sv
// Zero-latency AXI-Stream monitor: beat/packet/stall statistics and a one-shot
// packet capture buffer with a registered read port for the debug register bank.
`timescale 1ns/1ps

module axis_stream_tap #(
  parameter int C_AXIS_BYTEWIDTH = 4,
  parameter int C_CAPTURE_DEPTH  = 16,
  parameter int C_CNT_WIDTH      = 32
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [8*C_AXIS_BYTEWIDTH-1:0]       s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [8*C_AXIS_BYTEWIDTH-1:0]       m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic                                ctrl_clear,
  input  logic                                ctrl_arm,
  output logic [C_CNT_WIDTH-1:0]              beat_count,
  output logic [C_CNT_WIDTH-1:0]              pkt_count,
  output logic [C_CNT_WIDTH-1:0]              stall_count,
  output logic [1:0]                          cap_state,
  output logic [$clog2(C_CAPTURE_DEPTH):0]    cap_count,
  input  logic [$clog2(C_CAPTURE_DEPTH)-1:0]  rd_addr,
  output logic [8*C_AXIS_BYTEWIDTH-1:0]       rd_data,
  output logic                                rd_last
);

  // state        | meaning
  // ST_IDLE      | no capture requested
  // ST_ARMED     | waiting for the first beat of the next packet
  // ST_CAPTURING | storing beats until tlast or the buffer is full
  // ST_DONE      | buffer holds cap_count valid beats; waits for clear/arm

  localparam int DW = 8 * C_AXIS_BYTEWIDTH;
  localparam int AW = $clog2(C_CAPTURE_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(C_CAPTURE_DEPTH);
  localparam logic [AW:0] CAP_ONE   = (AW+1)'(1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_CAPTURING = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  logic hs;
  logic stall;

  logic [C_CNT_WIDTH-1:0] beat_q, beat_d;
  logic [C_CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [C_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                   sop_q, sop_d;
  cap_state_e             state_q, state_d;
  logic [AW:0]            cap_cnt_q, cap_cnt_d;
  logic [AW:0]            cap_cnt_inc;

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DW:0]            cap_mem_q [C_CAPTURE_DEPTH];
  logic [DW:0]            rd_word_d;
  logic [DW-1:0]          rd_data_q;
  logic                   rd_last_q;

  // The tap is wire-through; only observation logic sits behind it.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign s_axis_tready = m_axis_tready;

  assign hs    = s_axis_tvalid & m_axis_tready;
  assign stall = s_axis_tvalid & ~m_axis_tready;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v,
                                                      input logic en);
    logic [C_CNT_WIDTH-1:0] r;
    r = v;
    if (en && (v != {C_CNT_WIDTH{1'b1}})) begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  always_comb begin
    beat_d  = sat_inc(beat_q, hs);
    pkt_d   = sat_inc(pkt_q, hs & s_axis_tlast);
    stall_d = sat_inc(stall_q, stall);
    if (ctrl_clear) begin
      beat_d  = '0;
      pkt_d   = '0;
      stall_d = '0;
    end
  end

  // sop follows the stream even while a clear is in progress.
  always_comb begin
    sop_d = sop_q;
    if (hs) begin
      sop_d = s_axis_tlast;
    end
  end

  assign cap_cnt_inc = cap_cnt_q + CAP_ONE;

  always_comb begin
    state_d   = state_q;
    cap_cnt_d = cap_cnt_q;
    wr_en     = 1'b0;
    wr_addr   = cap_cnt_q[AW-1:0];
    if (ctrl_clear) begin
      state_d   = ST_IDLE;
      cap_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_arm) begin
            state_d   = ST_ARMED;
            cap_cnt_d = '0;
          end
        end
        ST_ARMED: begin
          if (hs && sop_q) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            cap_cnt_d = CAP_ONE;
            state_d   = s_axis_tlast ? ST_DONE : ST_CAPTURING;
          end
        end
        ST_CAPTURING: begin
          if (hs) begin
            wr_en     = 1'b1;
            cap_cnt_d = cap_cnt_inc;
            if (s_axis_tlast || (cap_cnt_inc == DEPTH_CNT)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (ctrl_arm) begin
            state_d   = ST_ARMED;
            cap_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_q    <= '0;
      pkt_q     <= '0;
      stall_q   <= '0;
      sop_q     <= 1'b1;
      state_q   <= ST_IDLE;
      cap_cnt_q <= '0;
    end else begin
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
      stall_q   <= stall_d;
      sop_q     <= sop_d;
      state_q   <= state_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  // Capture RAM: no reset so it maps onto distributed/block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en && !areset) begin
      cap_mem_q[wr_addr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_comb begin
    rd_word_d = cap_mem_q[rd_addr];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      rd_data_q <= rd_word_d[DW-1:0];
      rd_last_q <= rd_word_d[DW];
    end
  end

  assign beat_count  = beat_q;
  assign pkt_count   = pkt_q;
  assign stall_count = stall_q;
  assign cap_state   = state_q;
  assign cap_count   = cap_cnt_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;

endmodule

// File: tb/tb_axis_stream_tap.sv
// Directed bench for axis_stream_tap: passthrough, statistics, capture FSM,
// overflow, counter saturation (4-bit counter instance) and clear/reset priority.
`timescale 1ns/1ps

module tb_axis_stream_tap;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic          ctrl_clear, ctrl_arm;
  logic [31:0]   beat_count, pkt_count, stall_count;
  logic [1:0]    cap_state;
  logic [AW:0]   cap_count;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  logic          sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_rd_last;
  logic [DW-1:0] sat_m_tdata, sat_rd_data;
  logic [3:0]    sat_beat, sat_pkt, sat_stall;
  logic [1:0]    sat_state;
  logic [AW:0]   sat_cap_count;

  int errs   = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axis_stream_tap u_dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .ctrl_clear(ctrl_clear), .ctrl_arm(ctrl_arm),
    .beat_count(beat_count), .pkt_count(pkt_count), .stall_count(stall_count),
    .cap_state(cap_state), .cap_count(cap_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_last(rd_last)
  );

  axis_stream_tap #(.C_CNT_WIDTH(4)) u_sat (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(sat_s_tready),
    .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tlast(sat_m_tlast),
    .m_axis_tready(m_tready),
    .ctrl_clear(ctrl_clear), .ctrl_arm(ctrl_arm),
    .beat_count(sat_beat), .pkt_count(sat_pkt), .stall_count(sat_stall),
    .cap_state(sat_state), .cap_count(sat_cap_count),
    .rd_addr(rd_addr), .rd_data(sat_rd_data), .rd_last(sat_rd_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse_clear();
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
  endtask

  task automatic pulse_arm();
    ctrl_arm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic l);
    rd_addr = a;
    tick();
    chk({tag, "_data"}, 64'(rd_data), 64'(d));
    chk({tag, "_last"}, 64'(rd_last), 64'(l));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected end before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; s_tdata = 32'h1234_5678; s_tvalid = 1'b1; s_tlast = 1'b1;
    m_tready = 1'b0; ctrl_clear = 1'b0; ctrl_arm = 1'b0; rd_addr = '0;
    repeat (3) tick();

    chk("rst_beat",   64'(beat_count), 64'd0);
    chk("rst_pkt",    64'(pkt_count), 64'd0);
    chk("rst_stall",  64'(stall_count), 64'd0);
    chk("rst_state",  64'(cap_state), 64'd0);
    chk("rst_cnt",    64'(cap_count), 64'd0);
    chk("rst_rdata",  64'(rd_data), 64'd0);
    chk("rst_rlast",  64'(rd_last), 64'd0);
    chk("rst_pass_d", 64'(m_tdata), 64'h1234_5678);
    chk("rst_pass_v", 64'(m_tvalid), 64'd1);
    areset = 1'b0;
    s_tvalid = 1'b0;

    // random passthrough
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] d;
      logic v, r, l;
      d = $urandom();
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      s_tdata = d; s_tvalid = v; s_tlast = l; m_tready = r;
      #2;
      chk("pass_data",  64'(m_tdata), 64'(d));
      chk("pass_valid", 64'(m_tvalid), 64'(v));
      chk("pass_last",  64'(m_tlast), 64'(l));
      chk("pass_ready", 64'(s_tready), 64'(r));
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;

    // statistics: 3 packets of 5 beats, 4 stall cycles
    pulse_clear();
    chk("clr_beat", 64'(beat_count), 64'd0);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 5; b++) begin
        if (b == 2 || (p == 2 && b == 4)) begin
          s_tvalid = 1'b1; m_tready = 1'b0; s_tdata = 32'hDEAD;
          tick();
          s_tvalid = 1'b0; m_tready = 1'b1;
        end
        beat(32'(p * 16 + b), b == 4);
        if (p == 0 && b == 0) chk("beat_latency", 64'(beat_count), 64'd1);
      end
    end
    chk("cnt_beat",  64'(beat_count), 64'd15);
    chk("cnt_pkt",   64'(pkt_count), 64'd3);
    chk("cnt_stall", 64'(stall_count), 64'd4);

    // capture: arm mid-packet, partial packet skipped
    pulse_clear();
    beat(32'h50, 1'b0);
    beat(32'h51, 1'b0);
    pulse_arm();
    chk("arm_state", 64'(cap_state), 64'd1);
    chk("arm_cnt",   64'(cap_count), 64'd0);
    beat(32'h52, 1'b0);
    beat(32'h53, 1'b0);
    beat(32'h54, 1'b1);
    chk("skip_state", 64'(cap_state), 64'd1);
    chk("skip_cnt",   64'(cap_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      beat(32'(32'hA0 + i), i == 5);
      if (i == 0) begin
        chk("cap0_state", 64'(cap_state), 64'd2);
        chk("cap0_cnt",   64'(cap_count), 64'd1);
      end
    end
    chk("cap_state", 64'(cap_state), 64'd3);
    chk("cap_cnt",   64'(cap_count), 64'd6);
    read_chk("rd5", 4'd5, 32'hA5, 1'b1);
    read_chk("rd0", 4'd0, 32'hA0, 1'b0);
    read_chk("rd4", 4'd4, 32'hA4, 1'b0);

    // overflow: 40-beat packet into a 16-entry buffer
    pulse_clear();
    rd_addr = 4'd0;
    pulse_arm();
    for (int i = 0; i < 40; i++) begin
      beat(32'(32'h100 + i), i == 39);
      if (i == 0)  chk("rdw_old",  64'(rd_data), 64'hA0);
      if (i == 1)  chk("rdw_new",  64'(rd_data), 64'h100);
      if (i == 14) begin
        chk("ovf14_state", 64'(cap_state), 64'd2);
        chk("ovf14_cnt",   64'(cap_count), 64'd15);
      end
      if (i == 15) begin
        chk("ovf15_state", 64'(cap_state), 64'd3);
        chk("ovf15_cnt",   64'(cap_count), 64'd16);
      end
    end
    chk("ovf_state", 64'(cap_state), 64'd3);
    chk("ovf_cnt",   64'(cap_count), 64'd16);
    chk("ovf_beat",  64'(beat_count), 64'd40);
    chk("ovf_pkt",   64'(pkt_count), 64'd1);
    read_chk("rd15", 4'd15, 32'h10F, 1'b0);
    read_chk("rd1",  4'd1,  32'h101, 1'b0);
    pulse_arm();
    chk("rearm_state", 64'(cap_state), 64'd1);
    chk("rearm_cnt",   64'(cap_count), 64'd0);

    // saturation and clear priority
    pulse_clear();
    for (int i = 0; i < 20; i++) beat(32'(i), i == 19);
    chk("sat_beat",  64'(sat_beat), 64'd15);
    chk("wide_beat", 64'(beat_count), 64'd20);
    chk("sat_pkt",   64'(sat_pkt), 64'd1);
    s_tdata = 32'h66; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1; ctrl_clear = 1'b1;
    tick();
    s_tvalid = 1'b0; ctrl_clear = 1'b0;
    chk("clrhs_beat",     64'(beat_count), 64'd0);
    chk("clrhs_sat_beat", 64'(sat_beat), 64'd0);
    chk("clrhs_pkt",      64'(pkt_count), 64'd0);
    pulse_arm();
    beat(32'h77, 1'b0);
    chk("sop_mid_state", 64'(cap_state), 64'd1);
    beat(32'h78, 1'b1);
    chk("sop_eop_state", 64'(cap_state), 64'd1);
    beat(32'h79, 1'b0);
    chk("sop_cap_state", 64'(cap_state), 64'd2);
    chk("sop_cap_cnt",   64'(cap_count), 64'd1);
    beat(32'h7A, 1'b1);
    chk("sop_done_state", 64'(cap_state), 64'd3);
    chk("sop_done_cnt",   64'(cap_count), 64'd2);

    // clear and arm together mid-capture
    pulse_clear();
    pulse_arm();
    for (int i = 0; i < 3; i++) beat(32'(32'hC0 + i), 1'b0);
    chk("mid_state", 64'(cap_state), 64'd2);
    chk("mid_cnt",   64'(cap_count), 64'd3);
    ctrl_clear = 1'b1; ctrl_arm = 1'b1;
    tick();
    ctrl_clear = 1'b0; ctrl_arm = 1'b0;
    chk("clrarm_state", 64'(cap_state), 64'd0);
    chk("clrarm_cnt",   64'(cap_count), 64'd0);
    pulse_arm();
    chk("arm_after_clr", 64'(cap_state), 64'd1);

    // reset while armed mid-packet restores sop
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rst2_state", 64'(cap_state), 64'd0);
    chk("rst2_cnt",   64'(cap_count), 64'd0);
    chk("rst2_rdata", 64'(rd_data), 64'd0);
    chk("rst2_beat",  64'(beat_count), 64'd0);
    pulse_arm();
    beat(32'h91, 1'b0);
    chk("rst2_cap_state", 64'(cap_state), 64'd2);
    chk("rst2_cap_cnt",   64'(cap_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
